// File: rtl/chirp_pkg.sv
// Shared types for the chirp sweep generator: sweep mode encodings and FSM states.
package chirp_pkg;

   localparam int unsigned MODE_W = 2;

   // Encodings 0 and 3 both select a single up-leg followed by HOLD.
   typedef enum logic [MODE_W-1:0] {
      MODE_SINGLE     = 2'd0,
      MODE_SAW        = 2'd1,
      MODE_TRI        = 2'd2,
      MODE_SINGLE_ALT = 2'd3
   } mode_t;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUN_UP   = 2'd1,
      ST_RUN_DOWN = 2'd2,
      ST_HOLD     = 2'd3
   } state_t;

endpackage

// File: rtl/chirp_sweep_gen_phase_acc.sv
// Phase accumulator feeding the NCO: synchronous clear has priority over enable.
module phase_acc #(
   parameter int unsigned PHW = 48
) (
   input  logic           clk_96,
   input  logic           rst_n,
   input  logic           clr,
   input  logic           en,
   input  logic [PHW-1:0] inc,
   output logic [PHW-1:0] phase
);

   always_ff @(posedge clk_96) begin
      if (!rst_n) begin
         phase <= '0;
      end else if (clr) begin
         phase <= '0;
      end else if (en) begin
         phase <= phase + inc;
      end
   end

endmodule

// File: rtl/chirp_sweep_gen.sv
// Linear frequency sweep generator (single, sawtooth, triangle) with shadowed configuration.
module chirp_sweep_gen
   import chirp_pkg::*;
#(
   parameter int unsigned PHW = 48,
   parameter int unsigned RW  = 32,
   parameter int unsigned NW  = 16
) (
   input  logic              clk_96,
   input  logic              rst_n,
   input  logic              cfg_wr,
   input  logic [PHW-1:0]    cfg_f_start,
   input  logic [PHW-1:0]    cfg_f_step,
   input  logic [RW-1:0]     cfg_rate,
   input  logic [NW-1:0]     cfg_n_steps,
   input  logic [MODE_W-1:0] cfg_mode,
   output logic              cfg_ack,
   input  logic              start,
   output logic [PHW-1:0]    phi_inc,
   output logic [PHW-1:0]    phase,
   output logic              valid,
   output logic              busy,
   output logic              done
);

   logic [PHW-1:0] sh_f_start, sh_f_step, act_f_start, act_f_step;
   logic [RW-1:0]  sh_rate, act_rate, rate_cnt;
   logic [NW-1:0]  sh_n_steps, act_n_steps, step_cnt;
   mode_t          sh_mode, act_mode;
   state_t         state;
   logic           start_q;
   logic           start_edge;
   logic           acc_clr;

   assign start_edge = start & ~start_q;
   assign acc_clr    = start_edge | ~start;

   always_ff @(posedge clk_96) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         start_q     <= 1'b0;
         cfg_ack     <= 1'b0;
         done        <= 1'b0;
         valid       <= 1'b0;
         busy        <= 1'b0;
         phi_inc     <= '0;
         rate_cnt    <= '0;
         step_cnt    <= '0;
         sh_f_start  <= '0;
         sh_f_step   <= '0;
         sh_rate     <= '0;
         sh_n_steps  <= '0;
         sh_mode     <= MODE_SINGLE;
         act_f_start <= '0;
         act_f_step  <= '0;
         act_rate    <= '0;
         act_n_steps <= '0;
         act_mode    <= MODE_SINGLE;
      end else begin
         start_q <= start;
         cfg_ack <= cfg_wr;
         done    <= 1'b0;
         if (cfg_wr) begin
            sh_f_start <= cfg_f_start;
            sh_f_step  <= cfg_f_step;
            sh_rate    <= cfg_rate;
            sh_n_steps <= cfg_n_steps;
            sh_mode    <= mode_t'(cfg_mode);
         end
         if (start_edge) begin
            // A write landing on the start edge bypasses the shadow copy.
            act_f_start <= cfg_wr ? cfg_f_start : sh_f_start;
            act_f_step  <= cfg_wr ? cfg_f_step  : sh_f_step;
            act_rate    <= cfg_wr ? cfg_rate    : sh_rate;
            act_n_steps <= cfg_wr ? cfg_n_steps : sh_n_steps;
            act_mode    <= cfg_wr ? mode_t'(cfg_mode) : sh_mode;
            phi_inc     <= cfg_wr ? cfg_f_start : sh_f_start;
            rate_cnt    <= '0;
            step_cnt    <= '0;
            state       <= ST_RUN_UP;
            valid       <= 1'b1;
            busy        <= 1'b1;
         end else if (!start) begin
            state    <= ST_IDLE;
            phi_inc  <= '0;
            rate_cnt <= '0;
            step_cnt <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
         end else begin
            case (state)
               ST_RUN_UP, ST_RUN_DOWN: begin
                  // Leg end is tested before the rate counter, so n_steps=0 never steps.
                  if (step_cnt == act_n_steps) begin
                     done     <= 1'b1;
                     step_cnt <= '0;
                     rate_cnt <= '0;
                     if (state == ST_RUN_DOWN) begin
                        state <= ST_RUN_UP;
                     end else begin
                        case (act_mode)
                           MODE_SAW: phi_inc <= act_f_start;
                           MODE_TRI: state   <= ST_RUN_DOWN;
                           default:  state   <= ST_HOLD;
                        endcase
                     end
                  end else if (rate_cnt == act_rate) begin
                     phi_inc  <= (state == ST_RUN_UP) ? phi_inc + act_f_step
                                                      : phi_inc - act_f_step;
                     step_cnt <= step_cnt + NW'(1);
                     rate_cnt <= '0;
                  end else begin
                     rate_cnt <= rate_cnt + RW'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   phase_acc #(.PHW(PHW)) u_phase_acc (
      .clk_96 (clk_96),
      .rst_n  (rst_n),
      .clr    (acc_clr),
      .en     (valid),
      .inc    (phi_inc),
      .phase  (phase)
   );

endmodule

// File: tb/tb_chirp_sweep_gen.sv
// Self-checking bench for chirp_sweep_gen: directed sweeps plus randomized sweeps against a leg-level model.
module tb_chirp_sweep_gen;

   logic        clk_96 = 1'b0;
   logic        rst_n, cfg_wr, start;
   logic [47:0] cfg_f_start, cfg_f_step;
   logic [31:0] cfg_rate;
   logic [15:0] cfg_n_steps;
   logic [1:0]  cfg_mode;
   logic        cfg_ack, valid, busy, done;
   logic [47:0] phi_inc, phase;

   int n_cmp = 0;
   int n_err = 0;

   logic [47:0] exp_phi   [0:255];
   logic [47:0] exp_phase [0:255];
   bit          exp_done  [0:255];
   logic [47:0] obs_phi   [0:255];
   logic [47:0] obs_phase [0:255];
   int          done_cnt, ack_cnt;
   int          mid_wr_at = -1;
   logic [47:0] mid_f_start;

   always #5 clk_96 = ~clk_96;

   chirp_sweep_gen #(.PHW(48), .RW(32), .NW(16)) dut (
      .clk_96      (clk_96),
      .rst_n       (rst_n),
      .cfg_wr      (cfg_wr),
      .cfg_f_start (cfg_f_start),
      .cfg_f_step  (cfg_f_step),
      .cfg_rate    (cfg_rate),
      .cfg_n_steps (cfg_n_steps),
      .cfg_mode    (cfg_mode),
      .cfg_ack     (cfg_ack),
      .start       (start),
      .phi_inc     (phi_inc),
      .phase       (phase),
      .valid       (valid),
      .busy        (busy),
      .done        (done)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk_96);
      @(negedge clk_96);
   endtask

   task automatic set_cfg(input logic [47:0] fs, input logic [47:0] fst, input int rate,
                          input int n, input int mode);
      cfg_f_start = fs;
      cfg_f_step  = fst;
      cfg_rate    = 32'(rate);
      cfg_n_steps = 16'(n);
      cfg_mode    = 2'(mode);
   endtask

   task automatic write_cfg(input logic [47:0] fs, input logic [47:0] fst, input int rate,
                            input int n, input int mode);
      set_cfg(fs, fst, rate, n, mode);
      cfg_wr = 1'b1;
      tick();
      cfg_wr = 1'b0;
      chk("cfg_ack_high", 64'(cfg_ack), 64'd1);
      tick();
      chk("cfg_ack_low", 64'(cfg_ack), 64'd0);
   endtask

   // Expected per-cycle phi_inc/done built leg by leg: each step holds the value rate+1 cycles,
   // and every leg end occupies one cycle carrying done.
   task automatic build_model(input logic [47:0] fs, input logic [47:0] fst, input int rate,
                              input int n, input int mode, input int len);
      logic [47:0] v;
      int k;
      bit up, held;
      v = fs; up = 1'b1; held = 1'b0;
      exp_phi[0] = fs; exp_done[0] = 1'b0; k = 1;
      while (k < len) begin
         for (int s = 0; s < n; s++) begin
            for (int r = 0; r < rate; r++)
               if (k < len) begin exp_phi[k] = v; exp_done[k] = 1'b0; k++; end
            v = up ? v + fst : v - fst;
            if (k < len) begin exp_phi[k] = v; exp_done[k] = 1'b0; k++; end
         end
         if (!up) up = 1'b1;
         else if (mode == 1) v = fs;
         else if (mode == 2) up = 1'b0;
         else held = 1'b1;
         if (k < len) begin exp_phi[k] = v; exp_done[k] = 1'b1; k++; end
         while (held && k < len) begin exp_phi[k] = v; exp_done[k] = 1'b0; k++; end
      end
      exp_phase[0] = '0;
      for (int i = 1; i < len; i++) exp_phase[i] = exp_phase[i-1] + exp_phi[i-1];
   endtask

   task automatic run_sweep(input int len, input string tag, input bit wr_with_start);
      start = 1'b1;
      if (wr_with_start) cfg_wr = 1'b1;
      done_cnt = 0; ack_cnt = 0;
      for (int k = 0; k < len; k++) begin
         if (k == mid_wr_at) begin
            cfg_f_start = mid_f_start;
            cfg_wr = 1'b1;
         end
         tick();
         cfg_wr = 1'b0;
         obs_phi[k]   = phi_inc;
         obs_phase[k] = phase;
         if (done) done_cnt++;
         if (cfg_ack) ack_cnt++;
         chk($sformatf("%s_phi[%0d]", tag, k),   64'(phi_inc), 64'(exp_phi[k]));
         chk($sformatf("%s_phase[%0d]", tag, k), 64'(phase),   64'(exp_phase[k]));
         chk($sformatf("%s_done[%0d]", tag, k),  64'(done),    64'(exp_done[k]));
         chk($sformatf("%s_valid[%0d]", tag, k), 64'(valid),   64'd1);
         chk($sformatf("%s_busy[%0d]", tag, k),  64'(busy),    64'd1);
      end
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_phi"},   64'(phi_inc), 64'd0);
      chk({tag, "_phase"}, 64'(phase),   64'd0);
      chk({tag, "_valid"}, 64'(valid),   64'd0);
      chk({tag, "_busy"},  64'(busy),    64'd0);
      chk({tag, "_done"},  64'(done),    64'd0);
   endtask

   task automatic stop_sweep(input string tag);
      start = 1'b0;
      tick();
      check_idle(tag);
   endtask

   initial begin
      logic [47:0] rfs, rfst;
      int rrate, rn, rmode;

      rst_n = 1'b0; cfg_wr = 1'b0; start = 1'b0;
      set_cfg('0, '0, 0, 0, 0);
      tick(); tick();
      check_idle("reset");
      chk("reset_ack", 64'(cfg_ack), 64'd0);
      rst_n = 1'b1;
      tick();

      // Test 1: SINGLE up-leg then HOLD
      write_cfg(48'd1000, 48'd10, 2, 3, 0);
      build_model(48'd1000, 48'd10, 2, 3, 0, 16);
      run_sweep(16, "t1", 1'b0);
      chk("t1_phi_first", 64'(obs_phi[2]), 64'd1000);
      chk("t1_phi_step1", 64'(obs_phi[3]), 64'd1010);
      chk("t1_phi_hold",  64'(obs_phi[15]), 64'd1030);
      chk("t1_done_once", 64'(done_cnt), 64'd1);
      stop_sweep("t1_stop");

      // Test 2: TRI with rate 0
      write_cfg(48'd100, 48'd5, 0, 2, 2);
      build_model(48'd100, 48'd5, 0, 2, 2, 20);
      run_sweep(20, "t2", 1'b0);
      chk("t2_phi0", 64'(obs_phi[0]), 64'd100);
      chk("t2_phi1", 64'(obs_phi[1]), 64'd105);
      chk("t2_phi2", 64'(obs_phi[2]), 64'd110);
      chk("t2_phi4", 64'(obs_phi[4]), 64'd105);
      stop_sweep("t2_stop");

      // Test 3: SAW across the 2^48 wrap
      write_cfg(48'hFFFF_FFFF_FFFC, 48'd3, 0, 2, 1);
      build_model(48'hFFFF_FFFF_FFFC, 48'd3, 0, 2, 1, 12);
      run_sweep(12, "t3", 1'b0);
      chk("t3_phi1", 64'(obs_phi[1]), 64'hFFFF_FFFF_FFFF);
      chk("t3_phi2", 64'(obs_phi[2]), 64'd2);
      chk("t3_phi3", 64'(obs_phi[3]), 64'hFFFF_FFFF_FFFC);
      stop_sweep("t3_stop");

      // Test 4: config write mid-sweep only affects the next start
      write_cfg(48'd100, 48'd5, 0, 3, 1);
      build_model(48'd100, 48'd5, 0, 3, 1, 12);
      mid_wr_at = 4; mid_f_start = 48'd500;
      run_sweep(12, "t4a", 1'b0);
      mid_wr_at = -1;
      chk("t4_ack_once", 64'(ack_cnt), 64'd1);
      stop_sweep("t4_stop");
      build_model(48'd500, 48'd5, 0, 3, 1, 8);
      run_sweep(8, "t4b", 1'b0);
      chk("t4_restart", 64'(obs_phi[0]), 64'd500);
      stop_sweep("t4b_stop");

      // Test 5: stop mid RUN_UP, then reset mid-sweep
      write_cfg(48'd2000, 48'd7, 1, 5, 0);
      build_model(48'd2000, 48'd7, 1, 5, 0, 3);
      run_sweep(3, "t5a", 1'b0);
      stop_sweep("t5_stop");
      run_sweep(3, "t5b", 1'b0);
      rst_n = 1'b0; start = 1'b0;
      tick();
      check_idle("t5_reset");
      rst_n = 1'b1;
      tick();
      check_idle("t5_post_reset");
      // shadow was cleared by reset: zero config gives an immediate SINGLE leg end
      build_model('0, '0, 0, 0, 0, 4);
      run_sweep(4, "t5c", 1'b0);
      stop_sweep("t5c_stop");

      // Test 6: phase ramp with phi_inc held at 7
      write_cfg(48'd7, 48'd1, 10, 1, 0);
      build_model(48'd7, 48'd1, 10, 1, 0, 4);
      run_sweep(4, "t6", 1'b0);
      for (int i = 0; i < 4; i++) chk($sformatf("t6_phase%0d", i), 64'(obs_phase[i]), 64'(7 * i));
      stop_sweep("t6_stop");

      // Randomized sweeps; odd trials write config on the start edge itself
      for (int t = 0; t < 10; t++) begin
         rfs   = {$urandom, $urandom};
         rfst  = (t % 3 == 0) ? {$urandom, $urandom} : 48'($urandom_range(0, 65535));
         rrate = $urandom_range(0, 3);
         rn    = $urandom_range(0, 4);
         rmode = $urandom_range(0, 3);
         build_model(rfs, rfst, rrate, rn, rmode, 40);
         if (t % 2 == 1) begin
            set_cfg(rfs, rfst, rrate, rn, rmode);
            run_sweep(40, $sformatf("rnd%0d", t), 1'b1);
         end else begin
            write_cfg(rfs, rfst, rrate, rn, rmode);
            run_sweep(40, $sformatf("rnd%0d", t), 1'b0);
         end
         stop_sweep($sformatf("rnd%0d_stop", t));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
